// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter: shares one single-ported memory bank between NumReq
// requesters. A round-robin arbiter picks one request in IDLE, drives the
// bank for exactly one ACCESS cycle, then holds the registered read data
// in RESP until the owning requester accepts it. Only one transaction is in
// flight at a time, so sustained throughput is one transaction per 3 cycles.
module mem_bank_arbiter #(
    parameter  int NumReq    = 4,
    parameter  int AddrWidth = 8,
    parameter  int DataSize  = 2,
    localparam int DataBytes = 2 ** DataSize,
    localparam int DataWidth = 8 * DataBytes,
    localparam int IdxWidth  = $clog2(NumReq)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,

    // request channels, one per requester
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    input  logic [NumReq-1:0]                   req_we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]    req_wdata_i,
    input  logic [NumReq-1:0][DataBytes-1:0]    req_wstrb_i,

    // response channels; read data is shared, qualified by rsp_valid_o
    output logic [NumReq-1:0]                   rsp_valid_o,
    input  logic [NumReq-1:0]                   rsp_ready_i,
    output logic [DataWidth-1:0]                rsp_rdata_o,

    // memory bank side
    output logic                                mem_cs_o,
    output logic [AddrWidth-1:0]                mem_addr_o,
    output logic [DataWidth-1:0]                mem_wdata_o,
    output logic [DataBytes-1:0]                mem_wstrb_o,
    input  logic [DataWidth-1:0]                mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e                 state_q;
    logic [IdxWidth-1:0]    ptr_q;
    logic [IdxWidth-1:0]    owner_q;
    logic                   we_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [DataBytes-1:0]   wstrb_q;
    logic [DataWidth-1:0]   rdata_q;

    // Round-robin search: candidate gi is the requester gi places after ptr.
    logic [NumReq-1:0][IdxWidth-1:0] cand_idx;
    logic [NumReq-1:0]               cand_valid;
    logic                            grant_found;
    logic [IdxWidth-1:0]             grant_idx;
    logic [IdxWidth-1:0]             ptr_d;

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_cand
        // modulo wrap written as a compare so NumReq need not be a power of two
        assign cand_idx[gi] = (int'(ptr_q) + gi >= NumReq)
                            ? IdxWidth'(int'(ptr_q) + gi - NumReq)
                            : IdxWidth'(int'(ptr_q) + gi);
        assign cand_valid[gi] = req_valid_i[cand_idx[gi]];
    end

    // Pick the first valid candidate in search order (ptr, ptr+1, ...).
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (!grant_found && cand_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    // The requester after the winner gets first look next time.
    assign ptr_d = (int'(grant_idx) == NumReq - 1) ? '0 : grant_idx + 1'b1;

    // Sequencer: accept in IDLE, drive bank for one cycle, hold response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_found) begin
                        owner_q <= grant_idx;
                        we_q    <= req_we_i[grant_idx];
                        addr_q  <= req_addr_i[grant_idx];
                        wdata_q <= req_wdata_i[grant_idx];
                        wstrb_q <= req_wstrb_i[grant_idx];
                        ptr_q   <= ptr_d;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // bank read data is the pre-write word, also for writes
                    rdata_q <= mem_rdata_i;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i[owner_q]) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-requester handshake outputs, all forced low while in reset.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_port
        assign req_ready_o[gi] = rst_ni && (state_q == ST_IDLE) && grant_found
                               && (grant_idx == IdxWidth'(gi));
        assign rsp_valid_o[gi] = rst_ni && (state_q == ST_RESP)
                               && (owner_q == IdxWidth'(gi));
    end

    assign rsp_rdata_o = rdata_q;

    // Gating cs/wstrb with reset keeps a transaction aborted mid-ACCESS
    // from touching the bank.
    assign mem_cs_o    = rst_ni && (state_q == ST_ACCESS);
    assign mem_wstrb_o = (mem_cs_o && we_q) ? wstrb_q : '0;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// tb_mem_bank_arbiter: directed scenarios followed by random traffic. A
// transaction-level model predicts the grant sequence and each response;
// predicted responses queue up and a separate monitor pops them on every
// response handshake.
module tb_mem_bank_arbiter;

    localparam int NR = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NR-1:0]        req_valid_i;
    logic [NR-1:0]        req_ready_o;
    logic [NR-1:0]        req_we_i;
    logic [NR-1:0][7:0]   req_addr_i;
    logic [NR-1:0][31:0]  req_wdata_i;
    logic [NR-1:0][3:0]   req_wstrb_i;
    logic [NR-1:0]        rsp_valid_o;
    logic [NR-1:0]        rsp_ready_i;
    logic [31:0]          rsp_rdata_o;
    logic                 mem_cs_o;
    logic [7:0]           mem_addr_o;
    logic [31:0]          mem_wdata_o;
    logic [3:0]           mem_wstrb_o;
    logic [31:0]          mem_rdata_i;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    mem_bank_arbiter #(.NumReq(NR), .AddrWidth(8), .DataSize(2)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .mem_cs_o    (mem_cs_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory bank: combinational read, byte-strobed write on the clock edge.
    logic [31:0] bank [64] = '{default: 32'h0};
    assign mem_rdata_i = bank[mem_addr_o[7:2]];
    always @(posedge clk_i) begin
        if (mem_cs_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb_o[b]) bank[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
        end
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int          owner;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_who[$];
    int          grant_cyc[$];
    logic [31:0] ref_mem [64] = '{default: 32'h0};

    // Model view: a transaction is granted in an idle cycle, spends one cycle
    // on the bank, then waits for its owner to take the response.
    initial begin
        int          m_phase;
        int          m_ptr;
        int          m_owner;
        int          w;
        int          c;
        logic        p_we;
        logic [7:0]  p_addr;
        logic [31:0] p_wdata;
        logic [3:0]  p_wstrb;
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] own_mask;
        exp_t        e;
        m_phase = 0; m_ptr = 0; m_owner = 0;
        p_we = 1'b0; p_addr = '0; p_wdata = '0; p_wstrb = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                chk("rst_req_ready", req_ready_o, '0);
                chk("rst_rsp_valid", rsp_valid_o, '0);
                chk("rst_mem_cs", mem_cs_o, 1'b0);
                chk("rst_mem_wstrb", mem_wstrb_o, '0);
                m_phase = 0;
                m_ptr   = 0;
                exp_q.delete();
            end else if (m_phase == 0) begin
                w = -1;
                for (int k = 0; k < NR; k++) begin
                    c = (m_ptr + k) % NR;
                    if (w < 0 && req_valid_i[c]) w = c;
                end
                exp_ready = '0;
                if (w >= 0) exp_ready[w] = 1'b1;
                chk("grant", req_ready_o, exp_ready);
                chk("idle_mem_cs", mem_cs_o, 1'b0);
                chk("idle_rsp_valid", rsp_valid_o, '0);
                if (w >= 0) begin
                    p_we    = req_we_i[w];
                    p_addr  = req_addr_i[w];
                    p_wdata = req_wdata_i[w];
                    p_wstrb = req_wstrb_i[w];
                    e.owner = w;
                    e.data  = ref_mem[p_addr[7:2]];
                    exp_q.push_back(e);
                    grant_who.push_back(w);
                    grant_cyc.push_back(cyc);
                    m_owner = w;
                    m_ptr   = (w + 1) % NR;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                chk("access_mem_cs", mem_cs_o, 1'b1);
                chk("access_mem_addr", mem_addr_o, p_addr);
                chk("access_mem_wstrb", mem_wstrb_o, p_we ? p_wstrb : 4'h0);
                chk("access_mem_wdata", mem_wdata_o, p_wdata);
                chk("access_req_ready", req_ready_o, '0);
                chk("access_rsp_valid", rsp_valid_o, '0);
                for (int b = 0; b < 4; b++) begin
                    if (p_we && p_wstrb[b]) ref_mem[p_addr[7:2]][8*b +: 8] = p_wdata[8*b +: 8];
                end
                m_phase = 2;
            end else begin
                own_mask = '0;
                own_mask[m_owner] = 1'b1;
                chk("resp_rsp_valid", rsp_valid_o, own_mask);
                chk("resp_req_ready", req_ready_o, '0);
                chk("resp_mem_cs", mem_cs_o, 1'b0);
                if (rsp_ready_i[m_owner]) m_phase = 0;
            end
        end
    end

    // Monitor: pop one prediction per response handshake; data must not move
    // while a response is stalled.
    initial begin
        logic          stalled;
        logic [NR-1:0] last_valid;
        logic [31:0]   last_data;
        logic [NR-1:0] exp_mask;
        exp_t          e;
        stalled = 1'b0; last_valid = '0; last_data = '0;
        forever begin
            @(negedge clk_i);
            if (rst_ni && rsp_valid_o != '0) begin
                if (stalled) chk("rsp_stable", {rsp_valid_o, rsp_rdata_o}, {last_valid, last_data});
                if ((rsp_valid_o & rsp_ready_i) != '0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: got valid %0h with no outstanding request", rsp_valid_o);
                    end else begin
                        e = exp_q.pop_front();
                        exp_mask = '0;
                        exp_mask[e.owner] = 1'b1;
                        chk("rsp_owner", rsp_valid_o, exp_mask);
                        chk("rsp_data", rsp_rdata_o, e.data);
                        $display("rsp: requester %0d data %08h (expected %08h)", e.owner, rsp_rdata_o, e.data);
                    end
                    stalled = 1'b0;
                end else begin
                    stalled    = 1'b1;
                    last_valid = rsp_valid_o;
                    last_data  = rsp_rdata_o;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ready(input int r, input string name);
        int n = 0;
        @(negedge clk_i);
        while (!req_ready_o[r] && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o[r]) begin
            checks++;
            errors++;
            $display("FAIL %s: no req_ready_o[%0d] within 40 cycles", name, r);
        end
    endtask

    task automatic do_txn(input int r, input logic we, input logic [7:0] a,
                          input logic [31:0] wd, input logic [3:0] ws, output logic [31:0] rd);
        int n = 0;
        rd = '0;
        req_valid_i[r] = 1'b1;
        req_we_i[r]    = we;
        req_addr_i[r]  = a;
        req_wdata_i[r] = wd;
        req_wstrb_i[r] = ws;
        wait_ready(r, "txn_grant");
        tick();
        req_valid_i[r] = 1'b0;
        @(negedge clk_i);
        while (!rsp_valid_o[r] && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        if (!rsp_valid_o[r]) begin
            checks++;
            errors++;
            $display("FAIL txn_rsp: no rsp_valid_o[%0d] within 40 cycles", r);
        end else begin
            rd = rsp_rdata_o;
        end
        tick();
    endtask

    initial begin
        logic [31:0]   rd;
        logic [NR-1:0] g;
        int            base;
        int            n;

        rst_ni      = 1'b0;
        req_valid_i = '0;
        req_we_i    = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_wstrb_i = '0;
        rsp_ready_i = '1;
        repeat (3) tick();

        // All requesters valid straight out of reset: grants 0,1,2,3,0,...
        req_valid_i = '1;
        for (int i = 0; i < NR; i++) req_addr_i[i] = 8'(4 * i);
        @(negedge clk_i);
        chk("reset_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("reset_mem_addr", mem_addr_o, 8'h0);
        base = grant_who.size();
        tick();
        rst_ni = 1'b1;
        repeat (25) tick();
        req_valid_i = '0;
        repeat (6) tick();
        chk("t2_grant_count", grant_who.size() >= base + 8, 1'b1);
        if (grant_who.size() >= base + 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t2_order", grant_who[base + i], i % NR);
                if (i > 0) chk("t2_spacing", grant_cyc[base + i] - grant_cyc[base + i - 1], 3);
            end
        end

        // Write then read back through requester 0.
        do_txn(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, rd);
        chk("t1_write_rsp", rd, 32'h0);
        do_txn(0, 1'b0, 8'h10, 32'h0, 4'h0, rd);
        chk("t1_read", rd, 32'hDEADBEEF);

        // Partial-strobe write returns the old word.
        do_txn(1, 1'b1, 8'h20, 32'h11223344, 4'hF, rd);
        do_txn(1, 1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, rd);
        chk("t3_partial_rsp", rd, 32'h11223344);
        do_txn(1, 1'b0, 8'h20, 32'h0, 4'h0, rd);
        chk("t3_merged_read", rd, 32'h11BB33DD);

        // Stalled response from requester 2 blocks requester 1.
        rsp_ready_i    = 4'b1011;
        req_valid_i[2] = 1'b1;
        req_we_i[2]    = 1'b0;
        req_addr_i[2]  = 8'h10;
        wait_ready(2, "t4_grant2");
        tick();
        req_valid_i[2] = 1'b0;
        req_valid_i[1] = 1'b1;
        req_we_i[1]    = 1'b0;
        req_addr_i[1]  = 8'h20;
        repeat (6) tick();
        @(negedge clk_i);
        chk("t4_rsp_valid", rsp_valid_o, 4'b0100);
        chk("t4_rsp_data", rsp_rdata_o, 32'hDEADBEEF);
        chk("t4_req_blocked", req_ready_o, 4'b0000);
        tick();
        rsp_ready_i[2] = 1'b1;
        tick();
        @(negedge clk_i);
        chk("t4_next_grant", req_ready_o, 4'b0010);
        tick();
        req_valid_i[1] = 1'b0;
        repeat (4) tick();
        rsp_ready_i = '1;

        // Reset during ACCESS of a write: bank must not change.
        req_valid_i[0] = 1'b1;
        req_we_i[0]    = 1'b1;
        req_addr_i[0]  = 8'h30;
        req_wdata_i[0] = 32'hCAFEF00D;
        req_wstrb_i[0] = 4'hF;
        wait_ready(0, "t5_grant");
        tick();
        rst_ni         = 1'b0;
        req_valid_i[0] = 1'b0;
        @(negedge clk_i);
        chk("t5_cs_gated", mem_cs_o, 1'b0);
        chk("t5_no_rsp", rsp_valid_o, 4'b0000);
        tick();
        tick();
        rst_ni = 1'b1;
        repeat (3) tick();
        do_txn(0, 1'b0, 8'h30, 32'h0, 4'h0, rd);
        chk("t5_read_after_reset", rd, 32'h0);

        // Pointer wrap: lone requester 3 first, then 0 beats 3.
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        req_valid_i[3] = 1'b1;
        req_we_i[3]    = 1'b0;
        req_addr_i[3]  = 8'h04;
        @(negedge clk_i);
        chk("t6_lone_r3", req_ready_o, 4'b1000);
        tick();
        req_valid_i[3] = 1'b0;
        repeat (3) tick();
        req_valid_i[0] = 1'b1;
        req_we_i[0]    = 1'b0;
        req_addr_i[0]  = 8'h08;
        req_valid_i[3] = 1'b1;
        @(negedge clk_i);
        chk("t6_wrap_r0", req_ready_o, 4'b0001);
        tick();
        req_valid_i[0] = 1'b0;
        wait_ready(3, "t6_grant3");
        tick();
        req_valid_i[3] = 1'b0;
        repeat (4) tick();

        // Random traffic against the model, with occasional reset pulses.
        for (n = 0; n < 3000; n++) begin
            @(negedge clk_i);
            g = req_ready_o;
            @(posedge clk_i);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (!req_valid_i[i] || g[i] || $urandom_range(0, 19) == 0) begin
                    req_valid_i[i] = ($urandom_range(0, 2) != 0);
                    req_we_i[i]    = 1'($urandom_range(0, 1));
                    req_addr_i[i]  = 8'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
                    req_wdata_i[i] = $urandom;
                    req_wstrb_i[i] = 4'($urandom_range(0, 15));
                end
            end
            rsp_ready_i = 4'($urandom_range(0, 15));
            rst_ni      = ($urandom_range(0, 299) != 0);
        end

        req_valid_i = '0;
        rsp_ready_i = '1;
        rst_ni      = 1'b1;
        repeat (8) tick();
        chk("drain_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bank_arbiter.md
# mem_bank_arbiter

Round-robin arbiter and sequencer that shares one `mem_bank` instance between `NumReq` requesters. Each requester has a valid/ready request channel and a valid/ready response channel. The block owns the bank's `cs`/`addr`/`wdata`/`wstrb` inputs and registers the bank's combinational read data into a response. It sits between bus-side masters (CPU port, DMA, debug) and a single-ported bank.

## Interface

**Parameters**
- `NumReq`, default 4: number of requesters, ≥ 2.
- `AddrWidth`, default 8: byte address width, identical to the bank's.
- `DataSize`, default 2: log2 of bytes per word.
- `DataBytes`, localparam `2**DataSize`.
- `DataWidth`, localparam `8*DataBytes`.
- `IdxWidth`, localparam `$clog2(NumReq)`.

**Ports**
- `clk_i` in, 1: single clock; all state updates on its rising edge.
- `rst_ni` in, 1: reset, synchronous, active-low.
- `req_valid_i` in, [NumReq]: request valid per requester.
- `req_ready_o` out, [NumReq]: request accepted (one-hot or zero).
- `req_we_i` in, [NumReq]: 1 = write, 0 = read.
- `req_addr_i` in, [NumReq][AddrWidth]: byte address.
- `req_wdata_i` in, [NumReq][DataWidth]: write data.
- `req_wstrb_i` in, [NumReq][DataBytes]: byte write enables.
- `rsp_valid_o` out, [NumReq]: response valid (one-hot or zero).
- `rsp_ready_i` in, [NumReq]: response accepted.
- `rsp_rdata_o` out, DataWidth: shared response data, meaningful only for the asserted `rsp_valid_o` bit.
- `mem_cs_o` out, 1: bank chip select.
- `mem_addr_o` out, AddrWidth: bank address.
- `mem_wdata_o` out, DataWidth: bank write data.
- `mem_wstrb_o` out, DataBytes: bank byte strobes.
- `mem_rdata_i` in, DataWidth: bank read data. Combinational from `mem_addr_o`.

## Operation

**State machine: IDLE → ACCESS → RESP → IDLE**

- **IDLE**
  - If any `req_valid_i` bit is set, select a winner by round-robin.
  - Search order starts at pointer `ptr`, then `ptr+1`, and so on, wrapping modulo `NumReq`.
  - Drive `req_ready_o[winner]=1` combinationally in that cycle. All other `req_ready_o` bits are 0.
  - On that edge, latch `owner`, `we`, `addr`, `wdata` and `wstrb` of the winner.
  - On that edge, set `ptr <= (winner+1) mod NumReq` and go to ACCESS.
  - With no valid request, stay in IDLE.
- **ACCESS** (exactly one cycle)
  - `mem_cs_o=1`.
  - `mem_addr_o`/`mem_wdata_o` come from the latched values.
  - `mem_wstrb_o = we ? wstrb : 0`.
  - At the edge, capture `mem_rdata_i` into the response register.
  - A write therefore returns the word as it was *before* the write.
  - Go to RESP.
- **RESP**
  - `rsp_valid_o[owner]=1` and `rsp_rdata_o` = captured data, both held stable.
  - Leave for IDLE on the edge where `rsp_ready_i[owner]=1`.
  - `rsp_ready_i` bits of non-owners are ignored.
- **Outside ACCESS:** `mem_cs_o=0` and `mem_wstrb_o=0`. `mem_addr_o`/`mem_wdata_o` hold their latched values.

**Other rules**
- Full `AddrWidth` address is passed through; the bank ignores the low `DataSize` bits. No alignment checking.
- `we=1` with `wstrb=0` behaves as a read.
- A requester that deasserts `req_valid_i` before it is granted simply loses its turn; no state is kept.
- Only one transaction is outstanding at a time. No new request is accepted in ACCESS or RESP.

**Reset**
- `rst_ni=0` forces on the next edge: state=IDLE, `ptr=0`, latched registers=0, response register=0.
- While `rst_ni=0`, `req_ready_o`, `rsp_valid_o`, `mem_cs_o` and `mem_wstrb_o` are gated to 0.
- Reset asserted during ACCESS: `mem_cs_o` is already 0, so no bank write occurs. The transaction is dropped silently.

## Timing

- All outputs reset to 0. `ptr` and `owner` reset to 0.
- Request accepted at edge E0 (the IDLE cycle with ready=1).
- ACCESS cycle lies between E0 and E1; a write commits to the bank at E1.
- `rsp_valid_o` rises after E1.
- Minimum round trip is 3 cycles per transaction (IDLE, ACCESS, RESP with `rsp_ready_i` already high).
- Sustained throughput is 1 transaction per 3 cycles.
- `req_ready_o` depends combinationally on `req_valid_i` and state. Requesters must not make `req_valid_i` depend on `req_ready_o`.
- Starvation bound: a continuously valid requester is granted within `NumReq` grants.

## Test plan

1. Requester 0 writes `addr=0x10`, `wdata=0xDEADBEEF`, `wstrb=0xF`, then reads `0x10` → read response `0xDEADBEEF`. `mem_cs_o` is high for exactly 1 cycle per transaction.
2. All 4 requesters valid continuously from reset (`rsp_ready_i` all 1) → grant order 0,1,2,3,0,… with grants spaced exactly 3 cycles apart.
3. Write `0x11223344` to `0x20`, then write `wdata=0xAABBCCDD`, `wstrb=0b0101` → the second write's response returns `0x11223344`; a subsequent read returns `0x11BB33DD`.
4. Hold `rsp_ready_i[2]=0` for 5 cycles on a read by requester 2 while requester 1 is valid → `rsp_valid_o[2]` and `rsp_rdata_o` stay stable, `req_ready_o[1]` stays 0, and requester 1 is granted the cycle after the handshake.
5. Pull `rst_ni` low during ACCESS of a write to `0x30` (previously `0x0`) → no `rsp_valid_o`, `mem_cs_o=0`, and a read of `0x30` after reset returns `0x0`.
6. Only requester 3 valid with `ptr=0` → granted immediately. Afterwards requesters 0 and 3 are both valid → requester 0 wins, since `ptr` has wrapped to 0.
